// File: rtl/alu_cmd_sender.sv
// Initiator side of the ALU byte protocol: sends A, B and opcode as spaced
// single-cycle strobes, then waits for one result byte or times out.
module alu_cmd_sender #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_dato,
    input  logic               i_result_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_done,
    output logic               o_timeout,
    output logic               o_busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_A   = 3'd1;
    localparam logic [2:0] ST_GAP_A    = 3'd2;
    localparam logic [2:0] ST_SEND_B   = 3'd3;
    localparam logic [2:0] ST_GAP_B    = 3'd4;
    localparam logic [2:0] ST_SEND_OP  = 3'd5;
    localparam logic [2:0] ST_WAIT_RES = 3'd6;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    // A leaves on the capture edge itself, so only B and op need holding.
    typedef struct packed {
        logic [NB_DATA-1:0] b;
        logic [NB_OP-1:0]   op;
    } cmd_t;

    cmd_t       cmd_q;
    logic [2:0] state;
    logic [2:0] state_n;
    logic [3:0] gap_cnt;
    logic [7:0] wait_cnt;
    logic       gap_last;
    logic       wait_last;
    logic       in_gap;
    logic       in_wait;

    assign in_gap    = (state == ST_GAP_A) || (state == ST_GAP_B);
    assign in_wait   = (state == ST_WAIT_RES);
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign o_busy    = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:     if (i_start) state_n = ST_SEND_A;
            ST_SEND_A:   state_n = ST_GAP_A;
            ST_GAP_A:    if (gap_last) state_n = ST_SEND_B;
            ST_SEND_B:   state_n = ST_GAP_B;
            ST_GAP_B:    if (gap_last) state_n = ST_SEND_OP;
            ST_SEND_OP:  state_n = ST_WAIT_RES;
            // a result arriving on the timeout cycle still counts as success
            ST_WAIT_RES: if (i_result_valid || wait_last) state_n = ST_IDLE;
            default:     state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            gap_cnt   <= '0;
            wait_cnt  <= '0;
            o_valid   <= 1'b0;
            o_dato    <= '0;
            o_result  <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_n;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;

            if (state == ST_IDLE && i_start) begin
                cmd_q.b  <= i_data_b;
                cmd_q.op <= i_op;
            end

            // counters sit at zero outside their state, so entry always starts clean
            gap_cnt  <= (in_gap && !gap_last) ? gap_cnt + 4'd1 : 4'd0;
            wait_cnt <= (in_wait && state_n == ST_WAIT_RES) ? wait_cnt + 8'd1 : 8'd0;

            // outputs are decoded from the next state so they line up with it
            case (state_n)
                ST_SEND_A: begin
                    o_valid <= 1'b1;
                    o_dato  <= i_data_a;
                end
                ST_SEND_B: begin
                    o_valid <= 1'b1;
                    o_dato  <= cmd_q.b;
                end
                ST_SEND_OP: begin
                    o_valid <= 1'b1;
                    o_dato  <= NB_DATA'(cmd_q.op);
                end
                default: ;
            endcase

            if (in_wait) begin
                if (i_result_valid) begin
                    o_result <= i_result;
                    o_done   <= 1'b1;
                end else if (wait_last) begin
                    o_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sender.sv
// Bench for alu_cmd_sender: directed scenarios plus random traffic, each
// cycle compared against a phase-offset model of the command timeline.
module tb_alu_cmd_sender;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int G       = 2;
    localparam int T       = 16;

    logic               i_clock = 1'b0;
    logic               i_reset;
    logic               i_start;
    logic [NB_DATA-1:0] i_data_a;
    logic [NB_DATA-1:0] i_data_b;
    logic [NB_OP-1:0]   i_op;
    logic               o_valid;
    logic [NB_DATA-1:0] o_dato;
    logic               i_result_valid;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] o_result;
    logic               o_done;
    logic               o_timeout;
    logic               o_busy;

    always #5 i_clock = ~i_clock;

    alu_cmd_sender #(
        .NB_DATA   (NB_DATA),
        .NB_OP     (NB_OP),
        .GAP_CYCLES(G),
        .TIMEOUT   (T)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_data_a      (i_data_a),
        .i_data_b      (i_data_b),
        .i_op          (i_op),
        .o_valid       (o_valid),
        .o_dato        (o_dato),
        .i_result_valid(i_result_valid),
        .i_result      (i_result),
        .o_result      (o_result),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy)
    );

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a command is a timeline measured in cycles after the start edge.
    bit               m_act;
    int               m_p;
    logic [NB_DATA-1:0] m_a, m_b, m_dato, m_res;
    logic [NB_OP-1:0] m_op;
    bit               m_done, m_to, m_valid;

    task automatic model_edge();
        m_done  = 0;
        m_to    = 0;
        if (i_reset) begin
            m_act  = 0;
            m_p    = 0;
            m_dato = '0;
            m_res  = '0;
        end else if (!m_act) begin
            if (i_start) begin
                m_act = 1;
                m_p   = 1;
                m_a   = i_data_a;
                m_b   = i_data_b;
                m_op  = i_op;
            end
        end else begin
            if (m_p >= 4 + 2*G && i_result_valid) begin
                m_res  = i_result;
                m_done = 1;
                m_act  = 0;
            end else if (m_p == 3 + 2*G + T) begin
                m_to  = 1;
                m_act = 0;
            end else begin
                m_p++;
            end
        end
        m_valid = m_act && (m_p == 1 || m_p == 2 + G || m_p == 3 + 2*G);
        if (m_valid) begin
            if (m_p == 1)          m_dato = m_a;
            else if (m_p == 2 + G) m_dato = m_b;
            else                   m_dato = NB_DATA'(m_op);
        end
    endtask

    task automatic step(input bit rst, input bit st, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] op, input bit rv, input logic [7:0] r);
        @(negedge i_clock);
        i_reset        = rst;
        i_start        = st;
        i_data_a       = a;
        i_data_b       = b;
        i_op           = op;
        i_result_valid = rv;
        i_result       = r;
        @(posedge i_clock);
        model_edge();
        #1;
        if (o_valid) strobes++;
        chk("valid",   32'(o_valid),   32'(m_valid));
        chk("dato",    32'(o_dato),    32'(m_dato));
        chk("result",  32'(o_result),  32'(m_res));
        chk("done",    32'(o_done),    32'(m_done));
        chk("timeout", 32'(o_timeout), 32'(m_to));
        chk("busy",    32'(o_busy),    32'(m_act));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 6'h00, 0, 8'h00);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_data_a = '0; i_data_b = '0;
        i_op = '0; i_result_valid = 1'b0; i_result = '0;
        m_act = 0; m_p = 0; m_dato = '0; m_res = '0; m_a = '0; m_b = '0; m_op = '0;

        step(1, 1, 8'h11, 8'h22, 6'h01, 1, 8'h55);
        step(1, 0, 8'h00, 8'h00, 6'h00, 0, 8'h00);
        chk("reset_busy", 32'(o_busy), 32'd0);
        idle(2);

        // V1 / V2: basic command, result two cycles after the op strobe
        strobes = 0;
        step(0, 1, 8'h07, 8'h05, 6'h20, 0, 8'h00);
        chk("v1_a_strobe", 32'(o_dato), 32'h07);
        idle(8);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'h0C);
        chk("v2_result", 32'(o_result), 32'h0C);
        chk("v2_done",   32'(o_done),   32'd1);
        chk("v2_strobes", 32'(strobes), 32'd3);
        idle(2);

        // V3: no result, timeout keeps old result
        step(0, 1, 8'h31, 8'h42, 6'h3F, 0, 8'h00);
        idle(6 + T);
        chk("v3_keep", 32'(o_result), 32'h0C);
        idle(2);

        // V4: start held with changing operands
        strobes = 0;
        for (int i = 0; i < 12; i++)
            step(0, 1, 8'($urandom), 8'($urandom), 6'($urandom), 0, 8'h00);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'h9D);
        chk("v4_strobes", 32'(strobes), 32'd3);
        idle(2);

        // V5: reset during GAP_B, then a fresh command
        step(0, 1, 8'h61, 8'h62, 6'h23, 0, 8'h00);
        idle(4);
        step(1, 1, 8'h00, 8'h00, 6'h00, 1, 8'h77);
        chk("v5_dato",   32'(o_dato),   32'd0);
        chk("v5_result", 32'(o_result), 32'd0);
        strobes = 0;
        idle(3);
        chk("v5_no_op", 32'(strobes), 32'd0);
        step(0, 1, 8'hFF, 8'h13, 6'h03, 0, 8'h00);
        idle(9);
        chk("v5_strobes", 32'(strobes), 32'd3);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'h44);
        idle(1);

        // V6: result strobes outside WAIT_RES are ignored
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'hAA);
        step(0, 1, 8'h01, 8'h02, 6'h03, 1, 8'hAA);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'hAA);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'hAA);
        chk("v6_keep", 32'(o_result), 32'h44);
        idle(4);
        step(0, 0, 8'h00, 8'h00, 6'h00, 1, 8'h5A);
        idle(1);

        // random traffic, including back-to-back restarts and stray resets
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) == 0, $urandom_range(3) == 0,
                 8'($urandom), 8'($urandom), 6'($urandom),
                 $urandom_range(11) == 0, 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sender.md
ALU_CMD_SENDER -- requirements
Module: alu_cmd_sender

Interface
REQ-001 Parameters SHALL be, one per line:
  NB_DATA, 8, byte width of the command/result stream.
  NB_OP, 6, opcode width (NB_OP <= NB_DATA).
  GAP_CYCLES, 2, idle cycles between byte strobes (legal 1..15).
  TIMEOUT, 255, cycles waited for a result before abort (legal 1..255).
REQ-002 Ports SHALL be, one per line:
  i_clock  in  1  single clock, all logic on rising edge.
  i_reset  in  1  synchronous, active-high reset.
  i_start  in  1  command request, sampled only in IDLE.
  i_data_a  in  NB_DATA  operand A.
  i_data_b  in  NB_DATA  operand B.
  i_op  in  NB_OP  opcode.
  o_valid  out  1  byte strobe to the ALU interface.
  o_dato  out  NB_DATA  byte presented with o_valid.
  i_result_valid  in  1  result strobe from the ALU interface.
  i_result  in  NB_DATA  result byte.
  o_result  out  NB_DATA  last captured result.
  o_done  out  1  one-cycle pulse, result captured.
  o_timeout  out  1  one-cycle pulse, result wait aborted.
  o_busy  out  1  high whenever state is not IDLE.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high, ports named i_clock and i_reset.

Function
REQ-004 The block SHALL be the initiator side of the ALU byte protocol: it sends A, then B, then opcode as three single-cycle o_valid strobes, then waits for one i_result_valid.
REQ-005 States SHALL be IDLE, SEND_A, GAP_A, SEND_B, GAP_B, SEND_OP, WAIT_RES.
REQ-006 In IDLE with i_start=1 at an edge, i_data_a, i_data_b, i_op SHALL be registered and state SHALL go to SEND_A; later input changes SHALL not affect the command.
REQ-007 o_valid and o_dato SHALL be registered Moore outputs: o_valid=1 for exactly one cycle in each SEND_* state, 0 otherwise.
REQ-008 o_dato SHALL be A in SEND_A, B in SEND_B, {zeros, op} (zero-extended to NB_DATA) in SEND_OP, and SHALL hold its last value when o_valid=0.
REQ-009 Each GAP_* state SHALL last exactly GAP_CYCLES cycles, counted by a gap counter reset on entry.
REQ-010 SEND_OP SHALL go to WAIT_RES next cycle; a wait counter SHALL clear on entry and increment each WAIT_RES cycle.
REQ-011 Timing SHALL be: i_start sampled at edge k -> A strobe in cycle k+1, B strobe in cycle k+2+GAP_CYCLES, op strobe in cycle k+3+2*GAP_CYCLES.
REQ-012 In WAIT_RES, i_result_valid=1 SHALL load o_result from i_result, pulse o_done for the next cycle, and return to IDLE.
REQ-013 If the wait counter reaches TIMEOUT without i_result_valid, o_timeout SHALL pulse one cycle, o_result SHALL be unchanged, state SHALL return to IDLE.
REQ-014 i_result_valid together with the timeout cycle SHALL be treated as success (o_done, no o_timeout).
REQ-015 i_result_valid outside WAIT_RES SHALL be ignored; o_result SHALL not change.
REQ-016 i_start outside IDLE SHALL be ignored (no queueing); i_start in the cycle o_done/o_timeout is high SHALL be accepted, since state is then IDLE.
REQ-017 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-018 i_reset=1 at an edge SHALL force IDLE, clear counters, and drive o_valid=0, o_dato=0, o_result=0, o_done=0, o_timeout=0, o_busy=0, overriding all other inputs.
REQ-019 Reset mid-command (any state) SHALL abort without emitting further strobes; the first i_start after reset deasserts SHALL start a fresh command.

Verification (GAP_CYCLES=2, TIMEOUT=16)
REQ-020 Bench SHALL cover:
  V1 start A=0x07, B=0x05, op=0x20 at edge k -> o_dato 0x07/0x05/0x20 strobed in cycles k+1, k+4, k+7, o_busy high from k+1.
  V2 V1 then i_result_valid with i_result=0x0C two cycles after op strobe -> o_result=0x0C, o_done one cycle, o_busy low same cycle.
  V3 op=0x3F, no i_result_valid -> o_timeout pulses after 16 WAIT_RES cycles, o_result keeps prior value 0x0C, no o_done.
  V4 i_start held high and operands changed during command -> only one command sent, with the originally latched values.
  V5 i_reset pulsed during GAP_B -> no op strobe, all outputs 0 next cycle; new start A=0xFF, B=0x13, op=0x03 runs V1 timing.
  V6 i_result_valid in IDLE and GAP_A with i_result=0xAA -> o_result unchanged, no o_done.
